// File: rtl/gray_bmp_expand.sv
// gray_bmp_expand
//
// Reads a frame buffer that holds a BMP header followed by one gray byte per
// pixel, and streams a 24-bit BMP byte stream: header bytes verbatim, then
// each gray byte three times (B, G, R). One RAM read is in flight at most.
//
// Ports:
//   clk        clock, everything on the rising edge
//   rst_n      asynchronous reset, ACTIVE-HIGH despite the legacy name
//   start      one-cycle pulse that begins a frame; only looked at in IDLE
//   RAM_valid  RAM read enable (only in FETCH)
//   RAM_addr   RAM read address (0 outside FETCH)
//   RAM_Q      RAM read data, valid the cycle after RAM_valid
//   out_valid  out_data carries a stream byte
//   out_data   stream byte (0 outside EMIT)
//   out_ready  consumer accepts the byte when out_valid && out_ready
//   busy       high in every state except IDLE
//   done       one-cycle pulse after the last byte is accepted
module gray_bmp_expand #(
    parameter int BYTE_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 20,
    parameter int HEADER_SIZE = 54,
    parameter int PIXEL_COUNT = 65536
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  RAM_valid,
    output logic [ADDR_WIDTH-1:0] RAM_addr,
    input  logic [BYTE_WIDTH-1:0] RAM_Q,
    output logic                  out_valid,
    output logic [BYTE_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done
);

    localparam int TOTAL_BYTES = HEADER_SIZE + 3 * PIXEL_COUNT;
    localparam int CNT_WIDTH   = $clog2(TOTAL_BYTES + 1);

    localparam logic [ADDR_WIDTH-1:0] HDR_END   = ADDR_WIDTH'(HEADER_SIZE);
    localparam logic [ADDR_WIDTH-1:0] FRAME_END = ADDR_WIDTH'(HEADER_SIZE + PIXEL_COUNT);
    localparam logic [CNT_WIDTH-1:0]  LAST_CNT  = CNT_WIDTH'(TOTAL_BYTES - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LATCH = 3'd2,
        EMIT  = 3'd3,
        FIN   = 3'd4
    } state_t;

    state_t                  state_reg,   state_next;
    logic [ADDR_WIDTH-1:0]   rd_addr_reg, rd_addr_next;
    logic [1:0]              rep_cnt_reg, rep_cnt_next;
    logic [CNT_WIDTH-1:0]    out_cnt_reg, out_cnt_next;
    logic [BYTE_WIDTH-1:0]   data_reg,    data_next;

    // The reset input is active-high; it only keeps its historical name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_reg   <= IDLE;
            rd_addr_reg <= '0;
            rep_cnt_reg <= '0;
            out_cnt_reg <= '0;
            data_reg    <= '0;
        end else begin
            state_reg   <= state_next;
            rd_addr_reg <= rd_addr_next;
            rep_cnt_reg <= rep_cnt_next;
            out_cnt_reg <= out_cnt_next;
            data_reg    <= data_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        rd_addr_next = rd_addr_reg;
        rep_cnt_next = rep_cnt_reg;
        out_cnt_next = out_cnt_reg;
        data_next    = data_reg;

        RAM_valid = 1'b0;
        RAM_addr  = '0;
        out_valid = 1'b0;
        out_data  = '0;
        busy      = 1'b1;
        done      = 1'b0;

        case (state_reg)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_next   = FETCH;
                    rd_addr_next = '0;
                    rep_cnt_next = '0;
                    out_cnt_next = '0;
                end
            end

            FETCH: begin
                RAM_valid  = 1'b1;
                RAM_addr   = rd_addr_reg;
                state_next = LATCH;
            end

            LATCH: begin
                data_next    = RAM_Q;
                rd_addr_next = rd_addr_reg + ADDR_WIDTH'(1);
                state_next   = EMIT;
            end

            EMIT: begin
                out_valid = 1'b1;
                out_data  = data_reg;
                if (out_ready) begin
                    out_cnt_next = out_cnt_reg + CNT_WIDTH'(1);
                    // rd_addr already points one past the byte on display,
                    // so "<= HEADER_SIZE" means the byte came from the header.
                    if (rd_addr_reg <= HDR_END) begin
                        state_next = (out_cnt_reg == LAST_CNT) ? FIN : FETCH;
                    end else if (rep_cnt_reg == 2'd2) begin
                        rep_cnt_next = '0;
                        state_next   = (rd_addr_reg == FRAME_END) ? FIN : FETCH;
                    end else begin
                        rep_cnt_next = rep_cnt_reg + 2'd1;
                    end
                end
            end

            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_gray_bmp_expand.sv
module tb_gray_bmp_expand;

    localparam int H    = 54;
    localparam int P    = 4;
    localparam int P16  = 16;
    localparam int AW   = 20;
    localparam int NTOT = H + 3 * P;   // 66

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;

    // small-frame instance (4 pixels)
    logic          start = 1'b0;
    logic          ram_valid;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_q = 8'h00;
    logic          out_valid;
    logic [7:0]    out_data;
    logic          out_ready = 1'b1;
    logic          busy;
    logic          done;

    // cycle-count instance (16 pixels)
    logic          start16 = 1'b0;
    logic          ram_valid16;
    logic [AW-1:0] ram_addr16;
    logic [7:0]    ram_q16 = 8'h00;
    logic          out_valid16;
    logic [7:0]    out_data16;
    logic          out_ready16 = 1'b1;
    logic          busy16;
    logic          done16;

    gray_bmp_expand #(.BYTE_WIDTH(8), .ADDR_WIDTH(AW), .HEADER_SIZE(H), .PIXEL_COUNT(P)) dut (
        .clk(clk), .rst_n(rst), .start(start),
        .RAM_valid(ram_valid), .RAM_addr(ram_addr), .RAM_Q(ram_q),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    gray_bmp_expand #(.BYTE_WIDTH(8), .ADDR_WIDTH(AW), .HEADER_SIZE(H), .PIXEL_COUNT(P16)) dut16 (
        .clk(clk), .rst_n(rst), .start(start16),
        .RAM_valid(ram_valid16), .RAM_addr(ram_addr16), .RAM_Q(ram_q16),
        .out_valid(out_valid16), .out_data(out_data16), .out_ready(out_ready16),
        .busy(busy16), .done(done16)
    );

    // RAM models with registered read
    logic [7:0] mem   [0:63];
    logic [7:0] mem16 [0:127];
    always @(posedge clk) if (ram_valid)   ram_q   <= mem[ram_addr[5:0]];
    always @(posedge clk) if (ram_valid16) ram_q16 <= mem16[ram_addr16[6:0]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // monitors: sample at the falling edge, handshake completes at the next rise
    logic [7:0] got_q[$];
    int         hs_q[$];
    int         done_cnt = 0, done_cyc = 0, max_addr = 0;
    int         cnt16 = 0, done16_cnt = 0, done16_cyc = 0, max16 = 0;

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            got_q.push_back(out_data);
            hs_q.push_back(cyc);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (ram_valid && int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
        if (out_valid16 && out_ready16) cnt16 = cnt16 + 1;
        if (done16) begin
            done16_cnt = done16_cnt + 1;
            done16_cyc = cyc;
        end
        if (ram_valid16 && int'(ram_addr16) > max16) max16 = int'(ram_addr16);
    end

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] pix [0:3];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        hs_q.delete();
        done_cnt = 0;
        max_addr = 0;
    endtask

    task automatic pulse_start(output int s);
        start = 1'b1;
        tick();
        s = cyc;
        start = 1'b0;
    endtask

    task automatic wait_bytes(input string tag, input int n);
        int k = 0;
        while (got_q.size() < n && k < 2000) begin
            tick();
            k++;
        end
        check({tag, "_reach"}, got_q.size(), n);
    endtask

    task automatic wait_done();
        int k = 0;
        while (done_cnt == 0 && k < 3000) begin
            tick();
            k++;
        end
        repeat (6) tick();
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_len"}, got_q.size(), NTOT);
        for (int i = 0; i < NTOT && i < got_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        check({tag, "_done_cnt"}, done_cnt, 1);
        check({tag, "_max_addr"}, max_addr, H + P - 1);
        check({tag, "_idle_busy"}, busy, 0);
        $display("frame %s: %0d bytes, done pulses %0d", tag, got_q.size(), done_cnt);
    endtask

    initial begin
        int s;
        pix[0] = 8'h10; pix[1] = 8'h80; pix[2] = 8'hFF; pix[3] = 8'h00;
        for (int i = 0; i < 64; i++)  mem[i]   = 8'h00;
        for (int i = 0; i < 128; i++) mem16[i] = 8'h00;
        for (int i = 0; i < H; i++) begin
            mem[i]   = 8'(i);
            mem16[i] = 8'(i);
            exp_q.push_back(8'(i));
        end
        for (int i = 0; i < P; i++) begin
            mem[H + i] = pix[i];
            repeat (3) exp_q.push_back(pix[i]);
        end
        for (int i = 0; i < P16; i++) mem16[H + i] = 8'(8'h20 + i);

        // reset state
        repeat (3) tick();
        check("rst_ram_valid", ram_valid, 0);
        check("rst_ram_addr", ram_addr, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        repeat (2) tick();

        // frame 1: ready always high, latency and header spacing
        clear_mon();
        out_ready = 1'b1;
        pulse_start(s);
        check("f1_fetch_valid", ram_valid, 1);
        check("f1_fetch_addr", ram_addr, 0);
        check("f1_fetch_busy", busy, 1);
        tick();
        check("f1_latch_valid", ram_valid, 0);
        check("f1_latch_out_valid", out_valid, 0);
        tick();
        check("f1_emit_valid", out_valid, 1);
        check("f1_emit_data", out_data, 0);
        wait_done();
        compare_stream("f1");
        check("f1_first_hs", (hs_q.size() > 0) ? hs_q[0] - s : -1, 2);
        for (int i = 1; i < H && i < hs_q.size(); i++)
            check($sformatf("f1_hdr_gap%0d", i), hs_q[i] - hs_q[i-1], 3);
        check("f1_frame_cycles", done_cyc - s + 1, 3 * H + 5 * P + 1);

        // frame 2: backpressure at rep 1 of the pixel 0x80, plus start while busy
        clear_mon();
        pulse_start(s);
        wait_bytes("f2", H + 4);
        out_ready = 1'b0;
        for (int i = 0; i < 7; i++) begin
            tick();
            check($sformatf("f2_bp_valid%0d", i), out_valid, 1);
            check($sformatf("f2_bp_data%0d", i), out_data, 8'h80);
            check($sformatf("f2_bp_cnt%0d", i), got_q.size(), H + 4);
        end
        out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done();
        compare_stream("f2");

        // frame 3: reset during the pixel phase, then a clean replay
        clear_mon();
        pulse_start(s);
        wait_bytes("f3", H + 6);
        rst = 1'b1;
        tick();
        check("f3_rst_busy", busy, 0);
        check("f3_rst_out_valid", out_valid, 0);
        check("f3_rst_ram_addr", ram_addr, 0);
        check("f3_rst_ram_valid", ram_valid, 0);
        rst = 1'b0;
        repeat (2) tick();
        clear_mon();
        pulse_start(s);
        wait_done();
        compare_stream("f3");

        // frame 4: 16-pixel instance, exact frame length and read range
        start16 = 1'b1;
        tick();
        s = cyc;
        start16 = 1'b0;
        begin
            int k = 0;
            while (done16_cnt == 0 && k < 3000) begin
                tick();
                k++;
            end
        end
        repeat (4) tick();
        check("f4_frame_cycles", done16_cyc - s + 1, 243);
        check("f4_done_cnt", done16_cnt, 1);
        check("f4_bytes", cnt16, H + 3 * P16);
        check("f4_max_addr", max16, H + P16 - 1);
        check("f4_idle_busy", busy16, 0);
        $display("frame f4: %0d bytes, done after %0d cycles", cnt16, done16_cyc - s + 1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
